// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Shared types, constants and helpers for the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int c_default_word_length = 8;

  function automatic int cnt_width_f(input int word_length);
    return $clog2(word_length + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_bit_counter.sv
// ============================================================================
// Module      : serializer_bit_counter
// Description : Loadable down-counter with zero/one detect; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serializer_bit_counter
  import serial_pkg::*;
#(
  parameter int CNT_WIDTH = cnt_width_f(c_default_word_length)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 is_zero,
  output logic                 is_one
);

  localparam logic [CNT_WIDTH-1:0] c_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_zero;

  assign w_zero  = (r_count == '0);
  assign count   = r_count;
  assign is_zero = w_zero;
  assign is_one  = (r_count == c_one);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && !w_zero) begin
      r_count <= r_count - c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_serializer_left.sv
// ============================================================================
// Module      : shift_serializer_left
// Description : Parallel-in, MSB-first serial-out transmitter with valid/done.
//               Define SERIALIZER_RECIRCULATE_EN to rotate instead of filling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_serializer_left
  import serial_pkg::*;
#(
  parameter int WORD_LENGTH = c_default_word_length,
  parameter int CNT_WIDTH   = cnt_width_f(WORD_LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sys_reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] parallelInput,
  input  logic                   shift_en,
  input  logic                   fill_bit,
  output logic                   busy,
  output logic                   serialOutput,
  output logic                   serialValid,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   bitCount,
  output logic [WORD_LENGTH-1:0] parallelOutput
);

  localparam logic [CNT_WIDTH-1:0] c_load_count = CNT_WIDTH'(WORD_LENGTH);

  state_t                 r_state;
  logic [WORD_LENGTH-1:0] r_shreg;
  logic                   r_busy;
  logic                   r_valid;
  logic                   r_done;

  logic                   w_load;
  logic                   w_shift;
  logic                   w_shift_in;
  logic                   w_cnt_one;
  logic                   w_unused_cnt_zero;

  assign w_load  = (r_state == IDLE) && start;
  assign w_shift = (r_state == SHIFT) && shift_en;

`ifdef SERIALIZER_RECIRCULATE_EN
  // Rotating keeps the operand intact for engines that reread it.
  logic w_unused_fill;
  assign w_unused_fill = fill_bit;
  assign w_shift_in    = r_shreg[WORD_LENGTH-1];
`else
  assign w_shift_in = fill_bit;
`endif

  serializer_bit_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (sys_reset),
    .load       (w_load),
    .load_value (c_load_count),
    .dec        (w_shift),
    .count      (bitCount),
    .is_zero    (w_unused_cnt_zero),
    .is_one     (w_cnt_one)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (sys_reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shreg <= parallelInput;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            r_shreg <= {r_shreg[WORD_LENGTH-2:0], w_shift_in};
            // Counter still shows the pre-decrement value here.
            if (w_cnt_one) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign serialValid    = r_valid;
  assign done           = r_done;
  assign serialOutput   = r_shreg[WORD_LENGTH-1];
  assign parallelOutput = r_shreg;

endmodule

`default_nettype wire

// File: tb/tb_shift_serializer_left.sv
// ============================================================================
// Module      : tb_shift_serializer_left
// Description : Directed self-checking bench for shift_serializer_left.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_serializer_left;

  logic       clk;
  logic       reset;
  logic       sys_reset;
  logic       start;
  logic [7:0] parallelInput;
  logic       shift_en;
  logic       fill_bit;
  logic       busy;
  logic       serialOutput;
  logic       serialValid;
  logic       done;
  logic [3:0] bitCount;
  logic [7:0] parallelOutput;

  int n_checks = 0;
  int n_pass   = 0;

  shift_serializer_left #(
    .WORD_LENGTH (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sys_reset      (sys_reset),
    .start          (start),
    .parallelInput  (parallelInput),
    .shift_en       (shift_en),
    .fill_bit       (fill_bit),
    .busy           (busy),
    .serialOutput   (serialOutput),
    .serialValid    (serialValid),
    .done           (done),
    .bitCount       (bitCount),
    .parallelOutput (parallelOutput)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " valid"}, 32'(serialValid), 32'd0);
    check({tag, " done"},  32'(done), 32'd0);
    check({tag, " cnt"},   32'(bitCount), 32'd0);
  endtask

  // Load a word, drive shift_en from a repeating 16-bit pattern and capture
  // bits per the consumer contract. exp_lat = cycles from load to done.
  task automatic xfer(input string tag, input logic [7:0] word, input logic [15:0] en_pat,
                      input logic fb, input logic poke_start, input int exp_lat);
    logic [7:0] got;
    int nbits;
    int dones;
    int cyc;
    got = '0;
    nbits = 0;
    dones = 0;
    parallelInput = word;
    fill_bit = fb;
    start = 1'b1;
    shift_en = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " load busy"}, 32'(busy), 32'd1);
    check({tag, " load valid"}, 32'(serialValid), 32'd1);
    for (cyc = 0; cyc < 40 && dones == 0; cyc++) begin
      shift_en = en_pat[cyc % 16];
      start = poke_start && (cyc % 3 == 1);
      if (poke_start) parallelInput = 8'h00;
      check($sformatf("%s cnt@%0d", tag, cyc), 32'(bitCount), 32'(8 - nbits));
      check($sformatf("%s nodone@%0d", tag, cyc), 32'(done), 32'd0);
      if (serialValid && shift_en) begin
        got = {got[6:0], serialOutput};
        nbits++;
      end
      tick();
      if (done) dones++;
    end
    shift_en = 1'b0;
    start = 1'b0;
    check({tag, " bits"}, 32'(nbits), 32'd8);
    check({tag, " data"}, 32'(got), 32'(word));
    check({tag, " done seen"}, 32'(dones), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " done busy"}, 32'(busy), 32'd1);
    check({tag, " done valid"}, 32'(serialValid), 32'd0);
    check({tag, " done cnt"}, 32'(bitCount), 32'd0);
    tick();
    check_idle({tag, " post"});
  endtask

  initial begin
    reset = 1'b0;
    sys_reset = 1'b0;
    start = 1'b0;
    parallelInput = 8'h00;
    shift_en = 1'b0;
    fill_bit = 1'b0;
    #1;
    check_idle("reset");
    check("reset pout", 32'(parallelOutput), 32'h00);
    check("reset sout", 32'(serialOutput), 32'd0);
    #11;
    reset = 1'b1;
    tick();
    tick();
    check_idle("idle");

    // A5, shift_en held high: last bit at edge N+8, done right after
    xfer("a5", 8'hA5, 16'hFFFF, 1'b0, 1'b0, 8);
`ifdef SERIALIZER_RECIRCULATE_EN
    check("a5 pout", 32'(parallelOutput), 32'hA5);
`else
    check("a5 pout", 32'(parallelOutput), 32'h00);
`endif

    // 81 with stall pattern 1,0,0,1 repeating: 8th transfer at cycle 15
    xfer("81", 8'h81, 16'b1001_1001_1001_1001, 1'b0, 1'b0, 16);

    // C3 with start/parallelInput=00 poked during SHIFT
    xfer("c3", 8'hC3, 16'hFFFF, 1'b0, 1'b1, 8);

    // sys_reset after three shifts of FF
    parallelInput = 8'hFF;
    fill_bit = 1'b1;
    start = 1'b1;
    shift_en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("sr mid cnt", 32'(bitCount), 32'd5);
    check("sr mid pout", 32'(parallelOutput), 32'hFF);
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    check_idle("sr clear");
    check("sr pout", 32'(parallelOutput), 32'h00);
    check("sr sout", 32'(serialOutput), 32'd0);
    tick();
    check_idle("sr hold");
    xfer("0f", 8'h0F, 16'hFFFF, 1'b0, 1'b0, 8);

    // Async reset between edges mid-transfer
    parallelInput = 8'hC3;
    start = 1'b1;
    shift_en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ar pre busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_idle("ar async");
    check("ar pout", 32'(parallelOutput), 32'h00);
    shift_en = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    tick();
    check_idle("ar release");

    // Fill/recirculate result
    xfer("3c", 8'h3C, 16'hFFFF, 1'b1, 1'b0, 8);
`ifdef SERIALIZER_RECIRCULATE_EN
    check("3c pout", 32'(parallelOutput), 32'h3C);
`else
    check("3c pout", 32'(parallelOutput), 32'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
